// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock,
// with valid/ready handshakes on input and output.
module bin2bcd_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam longint unsigned MAXBIN = (64'd1 << WIDTH) - 64'd1;

  // Reject parameter sets whose digit count cannot hold the largest input
  if (pow10(DIGITS) <= MAXBIN) begin : g_digits_check
    $error("bin2bcd_seq: DIGITS too small for WIDTH");
  end

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t                state_q, state_n;
  logic [WIDTH-1:0]      shift_q, shift_n;
  logic [BW-1:0]         work_q,  work_n;
  logic [CW-1:0]         cnt_q,   cnt_n;
  logic [BW-1:0]         bcd_q,   bcd_n;
  logic [BW-1:0]         corr;
  logic [BW+WIDTH-1:0]   shifted;
  logic [3:0]            digit;

  // Next-state and datapath
  always_comb begin
    state_n = state_q;
    shift_n = shift_q;
    work_n  = work_q;
    cnt_n   = cnt_q;
    bcd_n   = bcd_q;
    corr    = work_q;
    digit   = '0;

    for (int k = 0; k < int'(DIGITS); k++) begin
      digit = work_q[4*k +: 4];
      if (digit >= 4'd5) corr[4*k +: 4] = digit + 4'd3;
    end
    shifted = {corr[BW-2:0], shift_q, 1'b0};

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_n = bin;
          work_n  = '0;
          cnt_n   = CW'(WIDTH);
          state_n = CONV;
        end
      end
      CONV: begin
        {work_n, shift_n} = shifted;
        cnt_n = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_n   = shifted[BW+WIDTH-1 -: BW];
          state_n = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, datapath and handshake flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_n;
      shift_q   <= shift_n;
      work_q    <= work_n;
      cnt_q     <= cnt_n;
      bcd_q     <= bcd_n;
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
    end
  end

  assign bcd = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and exhaustive bench for bin2bcd_seq with a scoreboard of expected results.
module tb_bin2bcd_seq;

  localparam int unsigned W = 8;
  localparam int unsigned D = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    bin;
  logic            out_valid;
  logic            out_ready;
  logic [4*D-1:0]  bcd;

  int nvec = 0;
  int nerr = 0;
  logic [4*D-1:0] sb[$];

  bin2bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .bin(bin), .out_valid(out_valid), .out_ready(out_ready), .bcd(bcd)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4*D-1:0] dec_ref(input int unsigned v);
    logic [4*D-1:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int k = 0; k < int'(D); k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one value in IDLE and let it be accepted on the next edge
  task automatic send(input logic [W-1:0] v, input bit push);
    chk("in_ready_pre", 32'(in_ready), 32'd1);
    bin      = v;
    in_valid = 1'b1;
    if (push) sb.push_back(dec_ref(int'(v)));
    tick();
    in_valid = 1'b0;
  endtask

  // Wait for out_valid, check latency, hold-stability and handshake completion
  task automatic collect(input int hold, input int exp_lat);
    int lat;
    logic [4*D-1:0] exp;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    exp = (sb.size() > 0) ? sb.pop_front() : '0;
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_bcd", 32'(bcd), 32'(exp));
      tick();
    end
    out_ready = 1'b1;
    chk("bcd", 32'(bcd), 32'(exp));
    for (int k = 0; k < int'(D); k++) chk("digit_le9", 32'(bcd[4*k +: 4] <= 4'd9), 32'd1);
    tick();
    out_ready = 1'b0;
    chk("out_valid_clr", 32'(out_valid), 32'd0);
    chk("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; bin = '0;
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    rst = 1'b0;
    tick();

    // zero, max and decimal-carry boundaries
    send(8'd0, 1'b1);   collect(0, 8);
    send(8'd255, 1'b1); collect(0, 8);
    send(8'd99, 1'b1);  collect(0, 8);
    send(8'd100, 1'b1); collect(0, 8);

    // consumer stalls five cycles
    send(8'd137, 1'b1); collect(5, 8);

    // in_valid held with a new bin during conversion: ignored until IDLE
    chk("in_ready_pre", 32'(in_ready), 32'd1);
    bin = 8'd42; in_valid = 1'b1; sb.push_back(dec_ref(42));
    tick();
    bin = 8'd200;
    chk("busy_in_ready", 32'(in_ready), 32'd0);
    collect(0, 8);
    sb.push_back(dec_ref(200));
    tick();
    in_valid = 1'b0;
    chk("reaccept", 32'(in_ready), 32'd0);
    collect(0, 8);

    // reset on the fourth conversion cycle aborts without a result
    send(8'd255, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_bcd", 32'(bcd), 32'd0);
    seen = 1'b0;
    repeat (12) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    chk("abort_no_valid", 32'(seen), 32'd0);
    send(8'd7, 1'b1); collect(0, 8);

    // reset with in_valid high: capture only after reset falls
    rst = 1'b1; in_valid = 1'b1; bin = 8'd5;
    repeat (3) tick();
    chk("rst_hold_ready", 32'(in_ready), 32'd1);
    chk("rst_hold_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    sb.push_back(dec_ref(5));
    tick();
    in_valid = 1'b0;
    chk("post_rst_capture", 32'(in_ready), 32'd0);
    collect(0, 8);

    // exhaustive sweep
    for (int v = 0; v < (1 << W); v++) begin
      send(W'(v), 1'b1);
      collect(0, 8);
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
